// File: rtl/daq_request_queue.sv
// daq_request_queue
//
// Collects one-cycle sample strobes from NUM_CH channels and turns them into
// write requests for a downstream DAQ file state machine.
//   - Each channel has a one-word holding register with a pending flag.
//   - A round-robin arbiter moves one pending word per cycle into a DEPTH-entry
//     request FIFO as {file number, sample word}.
//   - A dispatch FSM pops the FIFO head and handshakes it out with
//     file_write / file_active.
//   - A sample that arrives while its holding register is still occupied is
//     dropped, which sets a sticky per-channel flag and bumps a saturating
//     counter.
//
// Ports
//   wb_clk          clock, all logic on the rising edge
//   wb_rst          synchronous active-high reset
//   ch_valid        per-channel one-cycle sample strobe
//   ch_data         sample words, channel i in bits [32i+31:32i]
//   overflow_clear  one-cycle clear of ch_overflow and drop_count
//   file_active     downstream state machine busy with a file transaction
//   file_num        file number of the request being issued
//   file_write      write request to the downstream state machine
//   file_read       always 0
//   file_write_data sample word of the request being issued
//   ch_overflow     sticky per-channel drop flags
//   drop_count      saturating count of dropped samples
//   fifo_level      current request FIFO occupancy
//   busy            anything pending, queued or in flight
module daq_request_queue #(
  parameter int         NUM_CH    = 4,
  parameter int         DEPTH     = 8,
  parameter logic [7:0] FILE_BASE = 8'h00,
  parameter bit         DEBUG     = 1'b0
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*32-1:0]     ch_data,
  input  logic                     overflow_clear,
  input  logic                     file_active,
  output logic [7:0]               file_num,
  output logic                     file_write,
  output logic                     file_read,
  output logic [31:0]              file_write_data,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [31:0]       hold [NUM_CH];
  logic [PW-1:0]     rr_ptr;
  logic [39:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic [NUM_CH-1:0] grant_vec;
  logic              push;
  logic              pop;
  logic [NUM_CH-1:0] drop_vec;
  logic [3:0]        drop_n;
  logic [16:0]       drop_sum;
  logic [PW:0]       cand_sum;
  logic [PW-1:0]     cand;

  // Debug hooks are simulation-only and intentionally have no logic here.
  if (DEBUG) begin : g_debug
  end

  // Round-robin search: the first pending channel at or after rr_ptr,
  // wrapping modulo NUM_CH (NUM_CH need not be a power of two).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(NUM_CH))
        cand_sum = cand_sum - (PW+1)'(NUM_CH);
      cand = cand_sum[PW-1:0];
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    push      = grant_any && (count != FULL_LVL);
    grant_vec = '0;
    if (push)
      grant_vec[grant_idx] = 1'b1;
    pop = (state == IDLE) && (count != '0) && !file_active;
  end

  // A strobe is dropped only when the holding register stays occupied through
  // this edge; a granted channel frees its register in time for a new word.
  always_comb begin
    drop_vec = ch_valid & pending & ~grant_vec;
    drop_n   = '0;
    for (int i = 0; i < NUM_CH; i++)
      drop_n = drop_n + 4'(drop_vec[i]);
    drop_sum = (overflow_clear ? 17'd0 : 17'(drop_count)) + 17'(drop_n);
  end

  // Per-channel capture, overflow bookkeeping and arbiter pointer.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      pending     <= '0;
      ch_overflow <= '0;
      drop_count  <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < NUM_CH; i++)
        hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && (!pending[i] || grant_vec[i])) begin
          hold[i]    <= ch_data[32*i +: 32];
          pending[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      ch_overflow <= (overflow_clear ? '0 : ch_overflow) | drop_vec;
      drop_count  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (push)
        rr_ptr <= (grant_idx == PW'(NUM_CH-1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Request storage; contents are don't-care while the slot is empty.
  always_ff @(posedge wb_clk) begin
    if (push)
      mem[wr_ptr] <= {FILE_BASE + 8'(grant_idx), hold[grant_idx]};
  end

  // FIFO pointers and occupancy. Push and pop on the same edge cancel out.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // Dispatch FSM. file_num/file_write_data are only loaded on a pop, so they
  // keep the last issued request while idle or waiting.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state           <= IDLE;
      file_write      <= 1'b0;
      file_num        <= '0;
      file_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            file_num        <= mem[rd_ptr][39:32];
            file_write_data <= mem[rd_ptr][31:0];
            file_write      <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (file_active) begin
            file_write <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!file_active)
            state <= IDLE;
        end
        default: begin
          file_write <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign file_read  = 1'b0;
  assign fifo_level = count;
  assign busy       = (|pending) || (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_daq_request_queue.sv
// tb_daq_request_queue
//
// Drives daq_request_queue (default parameters) with directed scenarios and a
// randomized phase, and compares every output each cycle against a queue-based
// reference model. A small downstream responder drives file_active.
module tb_daq_request_queue;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam logic [7:0] FILE_BASE = 8'h00;

  localparam int FA_HIGH = 0;
  localparam int FA_LOW  = 1;
  localparam int FA_RESP = 2;
  localparam int FA_RAND = 3;

  logic                   wb_clk;
  logic                   wb_rst;
  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH*32-1:0]   ch_data;
  logic                   overflow_clear;
  logic                   file_active;
  logic [7:0]             file_num;
  logic                   file_write;
  logic                   file_read;
  logic [31:0]            file_write_data;
  logic [NUM_CH-1:0]      ch_overflow;
  logic [15:0]            drop_count;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel slot, request queue, dispatch phase.
  logic [NUM_CH-1:0] m_pending;
  logic [31:0]       m_hold [NUM_CH];
  int                m_rr;
  logic [39:0]       m_q [$];
  int                m_st;
  logic              m_fw;
  logic [7:0]        m_fnum;
  logic [31:0]       m_fdata;
  logic [NUM_CH-1:0] m_ov;
  int                m_cnt;

  // Responder and request log.
  int          fa_mode;
  int          hold_left;
  logic        prev_fw;
  logic [7:0]  issued_num [$];
  logic [31:0] issued_data [$];

  daq_request_queue #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .FILE_BASE(FILE_BASE), .DEBUG(1'b0)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .overflow_clear(overflow_clear), .file_active(file_active),
    .file_num(file_num), .file_write(file_write), .file_read(file_read),
    .file_write_data(file_write_data), .ch_overflow(ch_overflow),
    .drop_count(drop_count), .fifo_level(fifo_level), .busy(busy)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [NUM_CH*32-1:0] randData();
    logic [NUM_CH*32-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++)
      d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // Next-edge behaviour from the current inputs, at the level of
  // "slots, a queue of requests and a handshake phase".
  task automatic modelStep();
    int          g;
    logic [39:0] entry;
    logic [39:0] head;
    bit          do_pop;
    if (wb_rst) begin
      m_pending = '0; m_rr = 0; m_q.delete(); m_st = 0; m_fw = 1'b0;
      m_fnum = '0; m_fdata = '0; m_ov = '0; m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) m_hold[i] = '0;
      return;
    end
    do_pop = (m_st == 0) && (m_q.size() > 0) && !file_active;
    g = -1;
    entry = '0;
    if (m_q.size() < DEPTH) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && m_pending[c]) g = c;
      end
    end
    if (g >= 0) begin
      entry = {8'(FILE_BASE + g), m_hold[g]};
      m_pending[g] = 1'b0;
      m_rr = (g + 1) % NUM_CH;
    end
    if (overflow_clear) begin
      m_ov = '0;
      m_cnt = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i]) begin
        if (!m_pending[i]) begin
          m_hold[i] = ch_data[32*i +: 32];
          m_pending[i] = 1'b1;
        end else begin
          m_ov[i] = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
    if (do_pop) head = m_q.pop_front();
    else head = '0;
    if (g >= 0) m_q.push_back(entry);
    case (m_st)
      0: if (do_pop) begin m_fw = 1'b1; m_fnum = head[39:32]; m_fdata = head[31:0]; m_st = 1; end
      1: if (file_active) begin m_fw = 1'b0; m_st = 2; end
      default: if (!file_active) m_st = 0;
    endcase
  endtask

  task automatic updateFileActive();
    case (fa_mode)
      FA_HIGH: file_active = 1'b1;
      FA_LOW:  file_active = 1'b0;
      default: begin
        if (!file_active) begin
          if (file_write && (fa_mode == FA_RESP || $urandom_range(0, 1) == 1)) begin
            file_active = 1'b1;
            hold_left = (fa_mode == FA_RESP) ? 10 : $urandom_range(1, 6);
          end
        end else if (hold_left <= 1) begin
          file_active = 1'b0;
        end else begin
          hold_left--;
        end
      end
    endcase
  endtask

  task automatic compareAll();
    checkOutput("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    checkOutput("file_write", 64'(file_write), 64'(m_fw));
    checkOutput("file_num", 64'(file_num), 64'(m_fnum));
    checkOutput("file_write_data", 64'(file_write_data), 64'(m_fdata));
    checkOutput("ch_overflow", 64'(ch_overflow), 64'(m_ov));
    checkOutput("drop_count", 64'(drop_count), 64'(m_cnt));
    checkOutput("busy", 64'(busy), 64'((|m_pending) || m_q.size() > 0 || m_st != 0));
    checkOutput("file_read", 64'(file_read), 64'd0);
    if (file_write && !prev_fw) begin
      issued_num.push_back(file_num);
      issued_data.push_back(file_write_data);
    end
    prev_fw = file_write;
  endtask

  // One clock: set inputs, advance the model, let the edge happen, compare.
  task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH*32-1:0] d,
                               input logic oc, input logic rst);
    updateFileActive();
    ch_valid = v;
    ch_data = d;
    overflow_clear = oc;
    wb_rst = rst;
    modelStep();
    @(posedge wb_clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int base_issued;
    wb_rst = 1'b1; ch_valid = '0; ch_data = '0; overflow_clear = 1'b0;
    file_active = 1'b0; fa_mode = FA_RESP; hold_left = 0; prev_fw = 1'b0;
    m_pending = '0; m_rr = 0; m_st = 0; m_fw = 1'b0; m_fnum = '0; m_fdata = '0;
    m_ov = '0; m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) m_hold[i] = '0;

    // Single request on channel 2 with a one-cycle-late responder.
    $display("[TB] single request latency");
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_write", 64'(file_write), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    issued_num.delete(); issued_data.delete();
    applyStimulus(4'b0100, {32'h0, 32'hCAFE0002, 32'h0, 32'h0}, 1'b0, 1'b0);
    checkOutput("t1_busy_e1", 64'(busy), 64'd1);
    checkOutput("t1_write_e1", 64'(file_write), 64'd0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("t1_level_e2", 64'(fifo_level), 64'd1);
    checkOutput("t1_write_e2", 64'(file_write), 64'd0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("t1_write_e3", 64'(file_write), 64'd1);
    checkOutput("t1_num_e3", 64'(file_num), 64'h02);
    checkOutput("t1_data_e3", 64'(file_write_data), 64'hCAFE0002);
    idleCycles(20);
    checkOutput("t1_requests", 64'(issued_num.size()), 64'd1);
    checkOutput("t1_busy_end", 64'(busy), 64'd0);
    checkOutput("t1_num_retained", 64'(file_num), 64'h02);

    // All channels at once from rr_ptr=0; downstream held busy first.
    $display("[TB] four channels, round robin order");
    applyStimulus('0, '0, 1'b0, 1'b1);
    issued_num.delete(); issued_data.delete();
    fa_mode = FA_HIGH;
    applyStimulus(4'b1111, {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000}, 1'b0, 1'b0);
    idleCycles(5);
    checkOutput("t2_level_peak", 64'(fifo_level), 64'd4);
    fa_mode = FA_RESP; hold_left = 1;
    idleCycles(80);
    checkOutput("t2_count", 64'(issued_num.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < issued_num.size()) begin
        checkOutput("t2_order_num", 64'(issued_num[i]), 64'(i));
        checkOutput("t2_order_data", 64'(issued_data[i]), 64'(32'hB0000000 + i));
      end

    // Twelve samples on channel 0 against a stalled downstream.
    $display("[TB] fifo full and drops");
    applyStimulus('0, '0, 1'b0, 1'b1);
    issued_num.delete(); issued_data.delete();
    fa_mode = FA_HIGH;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(4'b0001, {96'h0, 32'(32'h3000 + k)}, 1'b0, 1'b0);
      applyStimulus('0, '0, 1'b0, 1'b0);
    end
    checkOutput("t3_level", 64'(fifo_level), 64'd8);
    checkOutput("t3_overflow", 64'(ch_overflow), 64'b0001);
    checkOutput("t3_drops", 64'(drop_count), 64'd3);
    checkOutput("t3_busy", 64'(busy), 64'd1);
    fa_mode = FA_RESP; hold_left = 1;
    idleCycles(150);
    checkOutput("t3_count", 64'(issued_data.size()), 64'd9);
    for (int i = 0; i < 9; i++)
      if (i < issued_data.size())
        checkOutput("t3_data", 64'(issued_data[i]), 64'(32'h3000 + i));

    // Drop counter saturation, then clear with a simultaneous drop.
    $display("[TB] drop counter saturation");
    applyStimulus('0, '0, 1'b0, 1'b1);
    fa_mode = FA_HIGH;
    for (int k = 0; k < 20000; k++) begin
      if (m_cnt == 65535) break;
      applyStimulus(4'b1111, randData(), 1'b0, 1'b0);
    end
    checkOutput("t4_reached", 64'(drop_count), 64'hFFFF);
    applyStimulus(4'b1111, randData(), 1'b0, 1'b0);
    checkOutput("t4_saturated", 64'(drop_count), 64'hFFFF);
    applyStimulus(4'b0001, randData(), 1'b1, 1'b0);
    checkOutput("t4_clear_drop", 64'(drop_count), 64'd1);
    checkOutput("t4_clear_ovf", 64'(ch_overflow), 64'b0001);

    // Reset while a request is being issued with five more queued.
    $display("[TB] reset during issue");
    fa_mode = FA_LOW;
    applyStimulus('0, '0, 1'b0, 1'b1);
    issued_num.delete(); issued_data.delete();
    for (int k = 0; k < 40; k++) begin
      if (m_st == 1 && m_q.size() == 5) break;
      applyStimulus(4'b1111, randData(), 1'b0, 1'b0);
    end
    checkOutput("t5_pre_level", 64'(fifo_level), 64'd5);
    checkOutput("t5_pre_write", 64'(file_write), 64'd1);
    base_issued = issued_num.size();
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("t5_write", 64'(file_write), 64'd0);
    checkOutput("t5_level", 64'(fifo_level), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    fa_mode = FA_RESP; hold_left = 1;
    idleCycles(20);
    checkOutput("t5_no_more", 64'(issued_num.size()), 64'(base_issued));

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    fa_mode = FA_RAND;
    for (int k = 0; k < 3000; k++) begin
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = ($urandom_range(0, 2) == 0);
      applyStimulus(v, randData(), $urandom_range(0, 39) == 0, $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/daq_request_queue.md
DAQ_REQUEST_QUEUE -- requirements
Module: daq_request_queue

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sample channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, request FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter FILE_BASE, default 8'h00, file number of channel 0.
REQ-004 SHALL have parameter DEBUG, default 0, simulation-only messages, no functional effect.
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports wb_clk and wb_rst.
REQ-006 wb_clk  input  1  single clock; all logic on posedge.
REQ-007 wb_rst  input  1  synchronous active-high reset.
REQ-008 ch_valid  input  NUM_CH  one-cycle sample strobe per channel.
REQ-009 ch_data  input  NUM_CH*32  sample words; channel i in bits [32i+31:32i].
REQ-010 overflow_clear  input  1  one-cycle clear of ch_overflow and drop_count.
REQ-011 file_active  input  1  downstream DAQ state machine busy with a file transaction.
REQ-012 file_num  output  8  file number of the request being issued.
REQ-013 file_write  output  1  write request to downstream DAQ state machine.
REQ-014 file_read  output  1  constant 0.
REQ-015 file_write_data  output  32  sample word of the request being issued.
REQ-016 ch_overflow  output  NUM_CH  sticky per-channel drop flags.
REQ-017 drop_count  output  16  saturating count of dropped samples.
REQ-018 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 busy  output  1  high when any pending flag set, FIFO non-empty, or FSM not IDLE.

Function
REQ-020 Capture: ch_valid[i] high at an edge with pending[i]=0 SHALL load hold[i]<=ch_data[i] and set pending[i]; visible after that edge.
REQ-021 ch_valid[i] at the same edge pending[i] is granted SHALL load the new word and keep pending[i]=1 (no drop).
REQ-022 ch_valid[i] with pending[i]=1 and not granted SHALL discard the sample, set ch_overflow[i], increment drop_count saturating at 16'hFFFF.
REQ-023 Arbiter: each edge with any pending and fifo_level<DEPTH SHALL push one entry {FILE_BASE+i (8-bit wrap), hold[i]}, clear pending[i]; i = first pending index at or after rr_ptr, cyclic; rr_ptr<=i+1 mod NUM_CH.
REQ-024 FIFO full (level==DEPTH): no push; pending flags held; push and pop in same edge when not full SHALL leave level unchanged.
REQ-025 Dispatch FSM states IDLE, ISSUE, WAIT_DONE.
REQ-026 IDLE: FIFO non-empty and file_active=0 -> pop head to file_num/file_write_data, file_write<=1, go ISSUE.
REQ-027 ISSUE: hold file_write=1 and outputs stable until file_active=1; then file_write<=0, go WAIT_DONE.
REQ-028 WAIT_DONE: file_active=0 -> IDLE; next request no earlier than the following edge.
REQ-029 Latency, idle and empty: ch_valid sampled at edge 1, pushed at edge 2, file_write high after edge 3.
REQ-030 overflow_clear SHALL zero ch_overflow and drop_count; a drop at the same edge SHALL yield that bit=1 and drop_count=1.
REQ-031 file_num/file_write_data SHALL retain last issued values outside ISSUE.

Reset
REQ-032 wb_rst SHALL set all outputs 0, pending=0, rr_ptr=0, FIFO empty, FSM IDLE at the next edge.
REQ-033 Reset mid-transaction SHALL drop file_write after that edge and discard all queued and pending samples.

Verification
REQ-034 Idle, ch_valid[2]=1 data 32'hCAFE0002, file_active responds 1 cycle after file_write, low 10 cycles later -> file_write high after edge 3, file_num=8'h02, data 32'hCAFE0002, single request.
REQ-035 All 4 channels valid same cycle, rr_ptr=0 -> FIFO entries file_num 0,1,2,3 in order; fifo_level peaks 4 with file_active held high.
REQ-036 file_active held high, 12 samples on channel 0 every 2 cycles, DEPTH=8 -> 8 queued, 1 pending, 3 dropped: ch_overflow=4'b0001, drop_count=3.
REQ-037 drop_count at 16'hFFFF plus further drop -> stays 16'hFFFF; overflow_clear with simultaneous drop -> drop_count=1.
REQ-038 wb_rst during ISSUE with 5 entries queued -> file_write=0, fifo_level=0, busy=0 after the edge; no further requests.
